// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

   localparam int NUM_DIGITS_DEF = 4;
   localparam int MAX_DIGITS     = 16;

   // All anodes off; callers slice it down to their own digit count.
   localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

   typedef logic [$clog2(NUM_DIGITS_DEF)-1:0] digit_idx_t;
   typedef logic [3:0]                        nibble_t;

endpackage

// File: rtl/sseg_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks, at the last count of each period.
module sseg_tick_gen #(
   parameter int CLK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int            DW       = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt_q;
   logic [DW-1:0] div_cnt_d;

   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment bank with double-buffered
// display value, inter-digit blanking and leading-zero suppression.
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 16,
   parameter int LZ_BLANK     = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_mask,
   input  logic                    load,
   output logic [3:0]              hex_out,
   output logic                    digit_en,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp_n,
   output logic                    frame_start,
   output logic                    busy
);

   localparam int                      IW         = $clog2(NUM_DIGITS);
   localparam int                      BW         = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [IW-1:0]           IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0]           BLANK_INIT = BW'(BLANK_CYCLES);
   localparam logic [NUM_DIGITS-1:0]   AN_OFF     = ANODES_OFF[NUM_DIGITS-1:0];

   logic                    tick;
   logic                    wrap;

   logic [IW-1:0]           idx_q,        idx_d;
   logic [BW-1:0]           blank_cnt_q,  blank_cnt_d;
   logic [4*NUM_DIGITS-1:0] stage_val_q,  stage_val_d;
   logic [NUM_DIGITS-1:0]   stage_dp_q,   stage_dp_d;
   logic [4*NUM_DIGITS-1:0] shadow_q,     shadow_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
   logic                    pending_q,    pending_d;
   logic                    wrap_q,       wrap_d;

   nibble_t                 hex_out_q,    hex_out_d;
   logic                    digit_en_q,   digit_en_d;
   logic [NUM_DIGITS-1:0]   an_q,         an_d;
   logic                    dp_n_q,       dp_n_d;
   logic                    frame_start_q, frame_start_d;

   nibble_t                 shadow_nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   visible;
   logic                    upper_zero;

   sseg_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign shadow_nib[gi] = shadow_q[4*gi +: 4];
   end

   // Walk from the most significant digit down; a digit is a leading zero while
   // it and everything above it are zero. Digit 0 is exempt so "0" still shows.
   always_comb begin
      upper_zero = 1'b1;
      visible    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (shadow_nib[i] == 4'h0);
         visible[i] = digit_mask[i] && !((LZ_BLANK != 0) && (i > 0) && upper_zero);
      end
   end

   assign wrap = tick && (idx_q == IDX_LAST);

   always_comb begin
      idx_d       = idx_q;
      blank_cnt_d = blank_cnt_q;
      stage_val_d = stage_val_q;
      stage_dp_d  = stage_dp_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      pending_d   = pending_q;
      wrap_d      = wrap;

      if (tick) begin
         idx_d       = wrap ? '0 : idx_q + 1'b1;
         blank_cnt_d = BLANK_INIT;
      end else if (blank_cnt_q != '0) begin
         blank_cnt_d = blank_cnt_q - 1'b1;
      end

      // Promotion uses the staging contents from before any coincident load.
      if (wrap && pending_q) begin
         shadow_d    = stage_val_q;
         shadow_dp_d = stage_dp_q;
         pending_d   = 1'b0;
      end

      if (load) begin
         stage_val_d = value;
         stage_dp_d  = dp_in;
         pending_d   = 1'b1;
      end
   end

   always_comb begin
      an_d          = AN_OFF;
      digit_en_d    = 1'b0;
      dp_n_d        = 1'b1;
      hex_out_d     = shadow_nib[idx_q];
      frame_start_d = wrap_q;
      if ((blank_cnt_q == '0) && visible[idx_q]) begin
         an_d[idx_q] = 1'b0;
         digit_en_d  = 1'b1;
         dp_n_d      = ~shadow_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q         <= '0;
         blank_cnt_q   <= '0;
         stage_val_q   <= '0;
         stage_dp_q    <= '0;
         shadow_q      <= '0;
         shadow_dp_q   <= '0;
         pending_q     <= 1'b0;
         wrap_q        <= 1'b0;
         hex_out_q     <= '0;
         digit_en_q    <= 1'b0;
         an_q          <= AN_OFF;
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         blank_cnt_q   <= blank_cnt_d;
         stage_val_q   <= stage_val_d;
         stage_dp_q    <= stage_dp_d;
         shadow_q      <= shadow_d;
         shadow_dp_q   <= shadow_dp_d;
         pending_q     <= pending_d;
         wrap_q        <= wrap_d;
         hex_out_q     <= hex_out_d;
         digit_en_q    <= digit_en_d;
         an_q          <= an_d;
         dp_n_q        <= dp_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hex_out     = hex_out_q;
   assign digit_en    = digit_en_q;
   assign an          = an_q;
   assign dp_n        = dp_n_q;
   assign frame_start = frame_start_q;
   assign busy        = pending_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (4 digits, CLK_DIV=8, BLANK_CYCLES=2); a second
// instance with leading-zero suppression disabled shares all inputs.
module tb_sseg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_mask;
   logic        load;

   logic [3:0]  hex_out,  hex_out_b;
   logic        digit_en, digit_en_b;
   logic [3:0]  an,       an_b;
   logic        dp_n,     dp_n_b;
   logic        frame_start, frame_start_b;
   logic        busy,     busy_b;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sseg_scan_ctrl #(
      .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(1)
   ) dut (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_mask(digit_mask),
      .load(load), .hex_out(hex_out), .digit_en(digit_en), .an(an), .dp_n(dp_n),
      .frame_start(frame_start), .busy(busy)
   );

   sseg_scan_ctrl #(
      .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .LZ_BLANK(0)
   ) dut_nlz (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_mask(digit_mask),
      .load(load), .hex_out(hex_out_b), .digit_en(digit_en_b), .an(an_b), .dp_n(dp_n_b),
      .frame_start(frame_start_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      step(1);
      load  = 1'b0;
   endtask

   task automatic wait_fs(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (frame_start) break;
         step(1);
      end
      chk({tag, "_fs_seen"}, 16'(frame_start), 16'h1);
   endtask

   // Starts at offset 0 of a slot, ends at offset 0 of the next slot.
   task automatic check_slot(input string tag, input logic [3:0] an_exp, input logic [3:0] an2_exp,
                             input logic [3:0] hex_exp, input logic dpn_exp);
      chk({tag, "_blank_an"},  16'(an), 16'hF);
      chk({tag, "_blank_en"},  16'(digit_en), 16'h0);
      chk({tag, "_blank_hex"}, 16'(hex_out), 16'(hex_exp));
      step(2);
      chk({tag, "_an"},     16'(an), 16'(an_exp));
      chk({tag, "_an_nlz"}, 16'(an_b), 16'(an2_exp));
      chk({tag, "_en"},     16'(digit_en), (an_exp != 4'hF) ? 16'h1 : 16'h0);
      chk({tag, "_hex"},    16'(hex_out), 16'(hex_exp));
      chk({tag, "_dpn"},    16'(dp_n), 16'(dpn_exp));
      chk({tag, "_fs_low"}, 16'(frame_start), 16'h0);
      step(6);
   endtask

   initial begin
      reset      = 1'b1;
      value      = '0;
      dp_in      = '0;
      digit_mask = 4'hF;
      load       = 1'b0;
      step(2);
      chk("rst_an",   16'(an), 16'hF);
      chk("rst_en",   16'(digit_en), 16'h0);
      chk("rst_hex",  16'(hex_out), 16'h0);
      chk("rst_dpn",  16'(dp_n), 16'h1);
      chk("rst_fs",   16'(frame_start), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      reset = 1'b0;

      // 1: basic scan order, blanking and busy
      do_load(16'h12A4);
      chk("t1_busy_after_load", 16'(busy), 16'h1);
      wait_fs("t1");
      chk("t1_busy_at_fs", 16'(busy), 16'h0);
      check_slot("t1_s0", 4'hE, 4'hE, 4'h4, 1'b1);
      check_slot("t1_s1", 4'hD, 4'hD, 4'hA, 1'b1);
      check_slot("t1_s2", 4'hB, 4'hB, 4'h2, 1'b1);
      check_slot("t1_s3", 4'h7, 4'h7, 4'h1, 1'b1);
      chk("t1_next_fs", 16'(frame_start), 16'h1);

      // 2: leading-zero suppression
      do_load(16'h0050);
      wait_fs("t2a");
      check_slot("t2a_s0", 4'hE, 4'hE, 4'h0, 1'b1);
      check_slot("t2a_s1", 4'hD, 4'hD, 4'h5, 1'b1);
      check_slot("t2a_s2", 4'hF, 4'hB, 4'h0, 1'b1);
      check_slot("t2a_s3", 4'hF, 4'h7, 4'h0, 1'b1);
      do_load(16'h0000);
      wait_fs("t2b");
      check_slot("t2b_s0", 4'hE, 4'hE, 4'h0, 1'b1);
      check_slot("t2b_s1", 4'hF, 4'hD, 4'h0, 1'b1);
      check_slot("t2b_s2", 4'hF, 4'hB, 4'h0, 1'b1);
      check_slot("t2b_s3", 4'hF, 4'h7, 4'h0, 1'b1);

      // 3: digit mask and decimal point
      digit_mask = 4'b0101;
      dp_in      = 4'b0001;
      do_load(16'h8888);
      wait_fs("t3");
      check_slot("t3_s0", 4'hE, 4'hE, 4'h8, 1'b0);
      check_slot("t3_s1", 4'hF, 4'hF, 4'h8, 1'b1);
      check_slot("t3_s2", 4'hB, 4'hB, 4'h8, 1'b1);
      check_slot("t3_s3", 4'hF, 4'hF, 4'h8, 1'b1);
      digit_mask = 4'hF;
      dp_in      = 4'h0;

      // 4: load mid-frame takes effect only at the next frame boundary
      do_load(16'h2222);
      wait_fs("t4");
      check_slot("t4_s0", 4'hE, 4'hE, 4'h2, 1'b1);
      do_load(16'h1111);
      chk("t4_busy_after_load", 16'(busy), 16'h1);
      step(7);
      check_slot("t4_s2", 4'hB, 4'hB, 4'h2, 1'b1);
      check_slot("t4_s3", 4'h7, 4'h7, 4'h2, 1'b1);
      chk("t4_fs", 16'(frame_start), 16'h1);
      chk("t4_busy_at_fs", 16'(busy), 16'h0);
      check_slot("t4_n0", 4'hE, 4'hE, 4'h1, 1'b1);
      check_slot("t4_n1", 4'hD, 4'hD, 4'h1, 1'b1);
      check_slot("t4_n2", 4'hB, 4'hB, 4'h1, 1'b1);
      check_slot("t4_n3", 4'h7, 4'h7, 4'h1, 1'b1);

      // 5: load on the exact wrap edge with nothing pending
      chk("t5_fs_ref", 16'(frame_start), 16'h1);
      step(30);
      do_load(16'h3333);
      step(1);
      chk("t5_fs", 16'(frame_start), 16'h1);
      chk("t5_busy_kept", 16'(busy), 16'h1);
      check_slot("t5_s0", 4'hE, 4'hE, 4'h1, 1'b1);
      check_slot("t5_s1", 4'hD, 4'hD, 4'h1, 1'b1);
      check_slot("t5_s2", 4'hB, 4'hB, 4'h1, 1'b1);
      check_slot("t5_s3", 4'h7, 4'h7, 4'h1, 1'b1);
      chk("t5_fs2", 16'(frame_start), 16'h1);
      chk("t5_busy_clear", 16'(busy), 16'h0);
      check_slot("t5_n0", 4'hE, 4'hE, 4'h3, 1'b1);

      // 6: asynchronous reset in the middle of slot 2
      step(12);
      chk("t6_pre_an", 16'(an), 16'hB);
      reset = 1'b1;
      #1;
      chk("t6_async_an", 16'(an), 16'hF);
      chk("t6_async_en", 16'(digit_en), 16'h0);
      step(1);
      reset = 1'b0;
      step(1);
      chk("t6_restart_an",   16'(an), 16'hE);
      chk("t6_restart_en",   16'(digit_en), 16'h1);
      chk("t6_restart_hex",  16'(hex_out), 16'h0);
      chk("t6_restart_busy", 16'(busy), 16'h0);
      step(8);
      chk("t6_slot1_dark", 16'(an), 16'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
